// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and one-at-a-time transaction sequencer for the shared
// MSI snooping bus: broadcast, memory handshake, response return, timeout.
module snoop_bus_arbiter #(
    parameter int WORD_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] req_p1,
    input  logic [WORD_W-1:0] req_p2,
    input  logic [WORD_W-1:0] req_p3,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_data,
    output logic [WORD_W-1:0] bus_out,
    output logic [2:0]        grant,
    output logic              mem_req,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_data,
    output logic              busy,
    output logic              timeout
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BCAST, WAIT_MEM, RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        grant_q, grant_d;
    logic [WORD_W-1:0] bus_out_q, bus_out_d;
    logic [WORD_W-1:0] resp_data_q, resp_data_d;
    logic              mem_req_q, mem_req_d;
    logic              resp_valid_q, resp_valid_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic [2:0][WORD_W-1:0] req_vec;
    logic                   found;
    logic [1:0]             win;
    logic [2:0]             idx;
    logic [WORD_W-1:0]      win_word;
    logic [1:0]             cur_op;
    logic [1:0]             next_ptr;

    assign req_vec  = {req_p3, req_p2, req_p1};
    assign cur_op   = word_q[WORD_W-1 -: 2];
    assign next_ptr = (word_q[WORD_W-3 -: 2] == 2'd3) ? 2'd1 : word_q[WORD_W-3 -: 2] + 2'd1;

    // rr_ptr holds a processor id (1..3); scan starts there and wraps
    always_comb begin
        found    = 1'b0;
        win      = 2'd0;
        idx      = 3'd0;
        for (int i = 0; i < 3; i++) begin
            idx = {1'b0, rr_ptr_q} - 3'd1 + 3'(i);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (!found && req_vec[idx[1:0]][WORD_W-1 -: 2] != 2'b00) begin
                found = 1'b1;
                win   = idx[1:0];
            end
        end
        win_word                  = req_vec[win];
        win_word[WORD_W-3 -: 2]   = win + 2'd1;
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        word_d       = word_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        bus_out_d    = '0;
        resp_data_d  = resp_data_q;
        mem_req_d    = 1'b0;
        resp_valid_d = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    word_d    = win_word;
                    grant_d   = 3'b001 << win;
                    bus_out_d = win_word;
                    mem_req_d = (win_word[WORD_W-1 -: 2] == 2'b01) ||
                                (win_word[WORD_W-1 -: 2] == 2'b10);
                    state_d   = BCAST;
                end
            end
            BCAST: begin
                if (cur_op == 2'b11) begin
                    grant_d  = 3'b000;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (mem_ack) begin
                    resp_data_d  = mem_data;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    grant_d   = 3'b000;
                    rr_ptr_d  = next_ptr;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                grant_d  = 3'b000;
                rr_ptr_d = next_ptr;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 2'd1;
            word_q       <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            bus_out_q    <= '0;
            resp_data_q  <= '0;
            mem_req_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            word_q       <= word_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            bus_out_q    <= bus_out_d;
            resp_data_q  <= resp_data_d;
            mem_req_q    <= mem_req_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus_out    = bus_out_q;
    assign grant      = grant_q;
    assign mem_req    = mem_req_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = busy_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench for snoop_bus_arbiter: directed requests, queued expected
// bus/response/timeout events, and a monitor that checks them as they appear.
module tb_snoop_bus_arbiter;
    localparam int W = 9;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] rq [3];
    logic         mem_ack = 1'b0;
    logic [W-1:0] mem_data = '0;
    logic [W-1:0] bus_out, resp_data;
    logic [2:0]   grant;
    logic         mem_req, resp_valid, busy, timeout;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit mem_auto = 1'b0;

    typedef enum int {EV_BCAST = 0, EV_RESP = 1, EV_TMO = 2} ev_t;
    typedef struct {
        ev_t          kind;
        logic [2:0]   grant;
        logic [W-1:0] word;
        logic         mreq;
        int           cyc;
    } exp_t;
    exp_t         exp_q[$];
    logic [W-1:0] mdata_q[$];

    snoop_bus_arbiter #(.WORD_W(W), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .req_p1(rq[0]), .req_p2(rq[1]), .req_p3(rq[2]),
        .mem_ack(mem_ack), .mem_data(mem_data),
        .bus_out(bus_out), .grant(grant), .mem_req(mem_req),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(busy), .timeout(timeout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_bcast(logic [2:0] g, logic [W-1:0] w, logic mr, int c);
        exp_t e;
        e.kind = EV_BCAST; e.grant = g; e.word = w; e.mreq = mr; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic push_resp(logic [2:0] g, logic [W-1:0] d, int c);
        exp_t e;
        e.kind = EV_RESP; e.grant = g; e.word = d; e.mreq = 1'b0; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic push_tmo(int c);
        exp_t e;
        e.kind = EV_TMO; e.grant = 3'b000; e.word = '0; e.mreq = 1'b0; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(ev_t k);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", k, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(k), 32'(e.kind));
            if (e.cyc != 0) chk("event_cycle", 32'(cyc), 32'(e.cyc));
            case (e.kind)
                EV_BCAST: begin
                    chk("bcast_grant", 32'(grant), 32'(e.grant));
                    chk("bcast_bus", 32'(bus_out), 32'(e.word));
                    chk("bcast_mem_req", 32'(mem_req), 32'(e.mreq));
                end
                EV_RESP: begin
                    chk("resp_grant", 32'(grant), 32'(e.grant));
                    chk("resp_data", 32'(resp_data), 32'(e.word));
                end
                default: chk("timeout_grant", 32'(grant), 32'(e.grant));
            endcase
        end
    endtask

    // monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (bus_out != '0) check_ev(EV_BCAST);
            if (resp_valid)    check_ev(EV_RESP);
            if (timeout)       check_ev(EV_TMO);
        end
    end

    // requesters drop their word once granted
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++)
            if (grant[i]) rq[i] = '0;
    end

    // memory model: one-cycle ack in the cycle after mem_req
    always @(negedge clock) begin
        if (mem_auto && mem_req && !reset) begin
            @(posedge clock); #1;
            mem_ack  = 1'b1;
            mem_data = (mdata_q.size() > 0) ? mdata_q.pop_front() : '0;
            @(posedge clock); #1;
            mem_ack  = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) rq[i] = '0;
        mem_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()) + 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int i = 0; i < 3; i++) rq[i] = '0;

        // reset state
        do_reset();
        @(negedge clock);
        chk("reset_outputs", 32'({bus_out, grant, mem_req, resp_valid, resp_data, busy, timeout}), 32'd0);

        // 1: single read miss from P2
        mem_auto = 1'b1;
        tick();
        t0 = cyc;
        mdata_q.push_back(9'h0AA);
        push_bcast(3'b010, 9'h0C5, 1'b1, t0 + 1);
        push_resp(3'b010, 9'h0AA, t0 + 3);
        rq[1] = 9'h085;
        @(negedge clock);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            chk("t1_grant", 32'(grant), (k <= 3) ? 32'h2 : 32'h0);
        end
        drain(50);

        // 2: three simultaneous write misses, then P1+P3 after P3 was served
        do_reset();
        tick();
        mdata_q.push_back(9'h011);
        mdata_q.push_back(9'h022);
        mdata_q.push_back(9'h033);
        push_bcast(3'b001, 9'h123, 1'b1, 0);
        push_resp(3'b001, 9'h011, 0);
        push_bcast(3'b010, 9'h14C, 1'b1, 0);
        push_resp(3'b010, 9'h022, 0);
        push_bcast(3'b100, 9'h171, 1'b1, 0);
        push_resp(3'b100, 9'h033, 0);
        rq[0] = 9'h103;
        rq[1] = 9'h16C;
        rq[2] = 9'h111;
        drain(100);
        tick();
        mdata_q.push_back(9'h044);
        mdata_q.push_back(9'h055);
        push_bcast(3'b001, 9'h0A1, 1'b1, 0);
        push_resp(3'b001, 9'h044, 0);
        push_bcast(3'b100, 9'h0E2, 1'b1, 0);
        push_resp(3'b100, 9'h055, 0);
        rq[0] = 9'h081;
        rq[2] = 9'h082;
        drain(100);

        // 3: invalidate from P3
        tick();
        t0 = cyc;
        push_bcast(3'b100, 9'h1E7, 1'b0, t0 + 1);
        rq[2] = 9'h1C7;
        @(negedge clock);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            chk("t3_bus_nonzero", 32'(bus_out != '0), (k == 1) ? 32'd1 : 32'd0);
            chk("t3_busy", 32'(busy), (k == 1) ? 32'd1 : 32'd0);
        end
        drain(20);

        // 4: timeout with no mem_ack, then a new request is accepted
        mem_auto = 1'b0;
        tick();
        t0 = cyc;
        push_bcast(3'b001, 9'h0BF, 1'b1, t0 + 1);
        push_tmo(t0 + 18);
        rq[0] = 9'h09F;
        drain(100);
        mem_auto = 1'b1;
        tick();
        t0 = cyc;
        mdata_q.push_back(9'h1AB);
        push_bcast(3'b010, 9'h0CA, 1'b1, t0 + 1);
        push_resp(3'b010, 9'h1AB, t0 + 3);
        rq[1] = 9'h08A;
        drain(50);

        // 5: reset during WAIT_MEM, then a stray mem_ack
        mem_auto = 1'b0;
        tick();
        t0 = cyc;
        push_bcast(3'b001, 9'h0A1, 1'b1, t0 + 1);
        rq[0] = 9'h081;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("t5_outputs_after_reset", 32'({bus_out, grant, mem_req, resp_valid, resp_data, busy, timeout}), 32'd0);
        tick();
        mem_ack  = 1'b1;
        mem_data = 9'h155;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("t5_no_resp", 32'({resp_valid, busy}), 32'd0);
        end
        tick();
        mem_ack = 1'b0;

        // 6: mem_ack in IDLE and BCAST is ignored
        mem_ack  = 1'b1;
        mem_data = 9'h111;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            chk("t6_idle_ack", 32'({resp_valid, busy}), 32'd0);
        end
        tick();
        t0 = cyc;
        push_bcast(3'b001, 9'h0A1, 1'b1, t0 + 1);
        push_resp(3'b001, 9'h0F0, t0 + 4);
        rq[0] = 9'h081;
        tick();
        tick();
        mem_ack = 1'b0;
        tick();
        mem_ack  = 1'b1;
        mem_data = 9'h0F0;
        tick();
        mem_ack = 1'b0;
        drain(50);

        repeat (3) @(negedge clock);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
